karatsuba_seq: RTL and testbench

- Sequential 8x8 Karatsuba multiplier and the consumer end of the factor lookup ROM.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Issues three time-multiplexed lookups on a single external ROM port, in this order:
  - A = Xl*Yl
  - D = Xh*Yh
  - C = (Xl+Xh)*(Yl+Yh)
- Recombines the three factors into a 16-bit product and returns it over a valid/ready handshake.

---
 rtl/karatsuba_pkg.sv | 22 ++
 rtl/karatsuba_combine.sv | 29 ++
 rtl/karatsuba_seq.sv | 133 +++++++++++++
 tb/tb_karatsuba_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared types and constants for the sequential Karatsuba multiplier.
package karatsuba_pkg;

  localparam int W_DEF  = 8;
  localparam int H_DEF  = W_DEF / 2;
  localparam int AW_DEF = 2 * (H_DEF + 1);
  localparam int DW_DEF = 2 * (H_DEF + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    MID  = 3'd3,
    DONE = 3'd4
  } state_t;

  // One ROM address field for a plain half-operand: the carry bit is zero.
  function automatic logic [H_DEF:0] addr_field(input logic [H_DEF-1:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/karatsuba_combine.sv
// Karatsuba recombination: P = (D << W) + ((C - A - D) << H) + A.
// Purely combinational. The sum is formed in 2W+1 bits and then truncated,
// because the true product always fits in 2W bits.
module karatsuba_combine #(
  parameter int W  = 8,
  parameter int H  = W / 2,
  parameter int DW = 2 * (H + 1)
) (
  input  logic [DW-1:0]  A,
  input  logic [DW-1:0]  C,
  input  logic [DW-1:0]  D,
  output logic [2*W-1:0] P
);

  localparam int PW = 2 * W + 1;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_c;
  logic [PW-1:0] w_d;
  logic [PW-1:0] w_mid;

  assign w_a   = PW'(A);
  assign w_c   = PW'(C);
  assign w_d   = PW'(D);
  // Equals Xl*Yh + Xh*Yl, never negative.
  assign w_mid = w_c - w_a - w_d;
  assign P     = (2*W)'((w_d << W) + (w_mid << H) + w_a);

endmodule

// File: rtl/karatsuba_seq.sv
// Sequential 8x8 Karatsuba multiplier reading an external factor ROM.
// Three ROM lookups (Xl*Yl, Xh*Yh, (Xl+Xh)*(Yl+Yh)) are issued on one port,
// then recombined into the product.
// Optional build macro: KARATSUBA_SELFCHECK_EN adds a sticky err output that
// flags any product disagreeing with a behavioural X*Y.
module karatsuba_seq
  import karatsuba_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int H  = W / 2,
  parameter int AW = 2 * (H + 1),
  parameter int DW = 2 * (H + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic [AW-1:0]  rom_addr,
  input  logic [DW-1:0]  rom_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] P
`ifdef KARATSUBA_SELFCHECK_EN
  ,
  output logic           err
`endif
);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_d;
  logic [2*W-1:0] r_p;
  logic [2*W-1:0] w_p;
  logic [H:0]     w_xs;
  logic [H:0]     w_ys;

  // Half sums keep their carry; it lands in the top bit of each address field.
  assign w_xs = {1'b0, r_x[H-1:0]} + {1'b0, r_x[W-1:H]};
  assign w_ys = {1'b0, r_y[H-1:0]} + {1'b0, r_y[W-1:H]};
  assign P    = r_p;

  karatsuba_combine #(.W(W), .H(H), .DW(DW)) u_combine (
    .A (r_a),
    .C (rom_data),
    .D (r_d),
    .P (w_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state, ROM address and handshake outputs.
  always_comb begin
    w_next    = r_state;
    rom_addr  = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = LOW;
      end
      LOW: begin
        rom_addr = {1'b0, r_x[H-1:0], 1'b0, r_y[H-1:0]};
        w_next   = HIGH;
      end
      HIGH: begin
        rom_addr = {1'b0, r_x[W-1:H], 1'b0, r_y[W-1:H]};
        w_next   = MID;
      end
      MID: begin
        rom_addr = {w_xs, w_ys};
        w_next   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and factor/product registers; ROM data only sampled in LOW/HIGH/MID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_a <= '0;
      r_d <= '0;
      r_p <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x <= X;
          r_y <= Y;
        end
        LOW:  r_a <= rom_data;
        HIGH: r_d <= rom_data;
        MID:  r_p <= w_p;
        default: ;
      endcase
    end
  end

`ifdef KARATSUBA_SELFCHECK_EN
  logic [2*W-1:0] w_ref;
  logic           r_err;

  assign w_ref = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_y};
  assign err   = r_err;

  // Sticky mismatch flag, evaluated as the product is registered on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == MID && w_p != w_ref) begin
      r_err <= 1'b1;
`ifndef SYNTHESIS
      $error("karatsuba_seq: product 0x%0h differs from reference 0x%0h", w_p, w_ref);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_karatsuba_seq.sv
// Self-checking bench for karatsuba_seq with a behavioural factor ROM and a
// product scoreboard fed at operand acceptance.
module tb_karatsuba_seq;
  import karatsuba_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic [9:0]  rom_addr;
  logic [9:0]  rom_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] P;
`ifdef KARATSUBA_SELFCHECK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  // External ROM: product of the two 5-bit address fields.
  assign rom_data = {5'b0, rom_addr[9:5]} * {5'b0, rom_addr[4:0]};

  karatsuba_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
`ifdef KARATSUBA_SELFCHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard producer/consumer, sampled mid-cycle so handshakes are stable.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      sb_q.push_back({8'h00, X} * {8'h00, Y});
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected_out", {16'h0, P}, 32'hDEAD);
      else                  check_eq("sb_product", {16'h0, P}, {16'h0, sb_q.pop_front()});
    end
  end

  // Drive one pair with out_ready high, checking addresses, latency and handshakes.
  task automatic run_txn(input logic [7:0] x, input logic [7:0] y);
    logic [9:0] a_low, a_high, a_mid;
    logic [4:0] xs, ys;
    xs = {1'b0, x[3:0]} + {1'b0, x[7:4]};
    ys = {1'b0, y[3:0]} + {1'b0, y[7:4]};
    a_low  = {addr_field(x[3:0]), addr_field(y[3:0])};
    a_high = {addr_field(x[7:4]), addr_field(y[7:4])};
    a_mid  = {xs, ys};
    X = x; Y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("addr_low", {22'h0, rom_addr}, {22'h0, a_low});
    check_eq("ready_low", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check_eq("addr_high", {22'h0, rom_addr}, {22'h0, a_high});
    check_eq("valid_e1", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check_eq("addr_mid", {22'h0, rom_addr}, {22'h0, a_mid});
    check_eq("valid_e2", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check_eq("valid_e3", {31'h0, out_valid}, 32'h1);
    check_eq("ready_done", {31'h0, in_ready}, 32'h0);
    check_eq("p_done", {16'h0, P}, {16'h0, {8'h00, x} * {8'h00, y}});
    @(posedge clk); #1;
    check_eq("valid_e4", {31'h0, out_valid}, 32'h0);
    check_eq("ready_e4", {31'h0, in_ready}, 32'h1);
  endtask

  // Back-to-back stream: in_valid stays high, operands change once accepted.
  task automatic stream_pair(input logic [7:0] x, input logic [7:0] y);
    int waited;
    X = x; Y = y; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] corners[9];
    int waited;
    corners = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFE, 8'hFF};

    #2;
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_p", {16'h0, P}, 32'h0);
    check_eq("rst_addr", {22'h0, rom_addr}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(8'h12, 8'h34);
    check_eq("p_12x34", {16'h0, P}, 32'h03A8);
    run_txn(8'hFF, 8'hFF);
    check_eq("p_ffxff", {16'h0, P}, 32'hFE01);
    run_txn(8'h00, 8'hB7);
    check_eq("p_00xb7", {16'h0, P}, 32'h0000);

    // Backpressure: product held while downstream stalls.
    out_ready = 1'b0;
    X = 8'h0A; Y = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'h0, out_valid}, 32'h1);
      check_eq("bp_p", {16'h0, P}, 32'h006E);
      check_eq("bp_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_valid", {31'h0, out_valid}, 32'h0);
    check_eq("bp_release_ready", {31'h0, in_ready}, 32'h1);

    // Reset during HIGH discards the transaction.
    X = 8'h55; Y = 8'h66; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check_eq("mid_rst_ready", {31'h0, in_ready}, 32'h1);
    check_eq("mid_rst_p", {16'h0, P}, 32'h0);
    check_eq("mid_rst_addr", {22'h0, rom_addr}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(8'h03, 8'h05);
    check_eq("p_03x05", {16'h0, P}, 32'h000F);

    // Back-to-back sweep: corner grid then random pairs.
    foreach (corners[i])
      foreach (corners[j])
        stream_pair(corners[i], corners[j]);
    for (int k = 0; k < 2000; k++)
      stream_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    in_valid = 1'b0;

    waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("sb_drained", sb_q.size(), 32'h0);
`ifdef KARATSUBA_SELFCHECK_EN
    check_eq("selfcheck_err", {31'h0, err}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
